// File: rtl/arith_pkg.sv
// Shared arithmetic-datapath definitions used by the shift-add multiplier and shift-subtract divider.
package arith_pkg;

    localparam int unsigned DEF_WIDTH = 4;
    localparam int unsigned CNT_W     = $clog2(DEF_WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } arith_state_e;

    // Step counter width able to hold the value w.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/shift_sub_div_if.sv
// Start/busy/done handshake and operand/result bus of the sequential divider.
interface shift_sub_div_if
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH:0]   rem_o,
    output logic             q_o
);
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // rem_i[WIDTH] would be the carry out of the shift; it forces the subtraction if ever set.
    always_comb begin
        shifted = {rem_i[WIDTH-1:0], bit_i};
        trial   = shifted - {1'b0, divisor_i};
        q_o     = rem_i[WIDTH] | ~trial[WIDTH];
        rem_o   = q_o ? trial : shifted;
    end
endmodule

// File: rtl/shift_sub_div.sv
// Sequential restoring unsigned divider: one quotient bit per clock, MSB first, start/busy/done handshake.
module shift_sub_div
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic           clk,
    input  logic           n_rst,
    shift_sub_div_if.slave bus
);
    localparam int unsigned CW = cnt_width(WIDTH);

    arith_state_e   state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [WIDTH:0] rem_q, rem_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic           dbz_q, dbz_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic [WIDTH:0] step_rem;
    logic           step_q;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .bit_i     (q_q[WIDTH-1]),
        .divisor_i (dvsr_q),
        .rem_o     (step_rem),
        .q_o       (step_q)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            q_q     <= '0;
            dvsr_q  <= '0;
            dbz_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            q_q     <= q_d;
            dvsr_q  <= dvsr_d;
            dbz_q   <= dbz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        q_d     = q_q;
        dvsr_d  = dvsr_q;
        dbz_d   = dbz_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    dvsr_d = bus.divisor;
                    cnt_d  = CW'(WIDTH);
                    if (bus.divisor == '0) begin
                        // Zero divisor short-circuits straight to DONE with saturated quotient.
                        q_d     = '1;
                        rem_d   = {1'b0, bus.dividend};
                        dbz_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        q_d     = bus.dividend;
                        rem_d   = '0;
                        dbz_d   = 1'b0;
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                rem_d = step_rem;
                q_d   = {q_q[WIDTH-2:0], step_q};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = q_q;
    assign bus.remainder   = rem_q[WIDTH-1:0];
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_shift_sub_div.sv
// Scoreboard bench for shift_sub_div: directed vectors at WIDTH=4 and WIDTH=8, monitors pop on done.
module tb_shift_sub_div;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       dbz;
    } exp_t;

    logic clk;
    logic n_rst;
    int   checks;
    int   errors;
    int   cyc;
    int   pushed4, pushed8, dones4, dones8;

    exp_t q4[$];
    exp_t q8[$];

    shift_sub_div_if #(.WIDTH(4)) b4 ();
    shift_sub_div_if #(.WIDTH(8)) b8 ();

    shift_sub_div #(.WIDTH(4)) u_dut4 (.clk(clk), .n_rst(n_rst), .bus(b4));
    shift_sub_div #(.WIDTH(8)) u_dut8 (.clk(clk), .n_rst(n_rst), .bus(b8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int unsigned act, input int unsigned req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic exp_t model(input int unsigned a, input int unsigned b, input int unsigned w);
        exp_t e;
        if (b == 0) begin
            e.q   = 8'((1 << w) - 1);
            e.r   = 8'(a);
            e.dbz = 1'b1;
        end else begin
            e.q   = 8'(a / b);
            e.r   = 8'(a % b);
            e.dbz = 1'b0;
        end
        return e;
    endfunction

    // Monitor for the 4-bit divider.
    always @(negedge clk) begin
        if (n_rst && b4.done) begin
            exp_t e;
            dones4++;
            if (q4.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done4 actual=q%0d/r%0d required=no_done", b4.quotient, b4.remainder);
            end else begin
                e = q4.pop_front();
                checks++;
                if (8'(b4.quotient) !== e.q || 8'(b4.remainder) !== e.r || b4.div_by_zero !== e.dbz) begin
                    errors++;
                    $display("FAIL result4 actual=q%0d r%0d z%0d required=q%0d r%0d z%0d",
                             b4.quotient, b4.remainder, b4.div_by_zero, e.q, e.r, e.dbz);
                end
            end
        end
    end

    // Monitor for the 8-bit divider.
    always @(negedge clk) begin
        if (n_rst && b8.done) begin
            exp_t e;
            dones8++;
            if (q8.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done8 actual=q%0d/r%0d required=no_done", b8.quotient, b8.remainder);
            end else begin
                e = q8.pop_front();
                checks++;
                if (b8.quotient !== e.q || b8.remainder !== e.r || b8.div_by_zero !== e.dbz) begin
                    errors++;
                    $display("FAIL result8 actual=q%0d r%0d z%0d required=q%0d r%0d z%0d",
                             b8.quotient, b8.remainder, b8.div_by_zero, e.q, e.r, e.dbz);
                end
            end
        end
    end

    task automatic wait_idle4();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!b4.busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("idle4_timeout", 1, 0);
    endtask

    task automatic wait_idle8();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!b8.busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("idle8_timeout", 1, 0);
    endtask

    // Drive one start pulse into the idle 4-bit divider; returns 1ns after the accepting edge.
    task automatic issue4(input int unsigned a, input int unsigned b, input bit push);
        wait_idle4();
        b4.dividend = 4'(a);
        b4.divisor  = 4'(b);
        b4.start    = 1'b1;
        if (push) begin
            q4.push_back(model(a, b, 4));
            pushed4++;
        end
        @(posedge clk);
        #1 b4.start = 1'b0;
    endtask

    task automatic run4(input int unsigned a, input int unsigned b);
        issue4(a, b, 1'b1);
        wait_idle4();
    endtask

    task automatic run8(input int unsigned a, input int unsigned b);
        wait_idle8();
        b8.dividend = 8'(a);
        b8.divisor  = 8'(b);
        b8.start    = 1'b1;
        q8.push_back(model(a, b, 8));
        pushed8++;
        @(posedge clk);
        #1 b8.start = 1'b0;
        wait_idle8();
    endtask

    // Cycles after acceptance until done is seen, plus how many of those had busy high.
    task automatic measure4(output int lat, output int busy_cycles);
        lat = 0;
        busy_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (b4.busy) busy_cycles++;
            if (b4.done) break;
        end
    endtask

    initial begin
        int lat, bc, n;
        int t[3];

        checks = 0; errors = 0; cyc = 0;
        pushed4 = 0; pushed8 = 0; dones4 = 0; dones8 = 0;
        n_rst = 1'b0;
        b4.start = 1'b0; b4.dividend = '0; b4.divisor = '0;
        b8.start = 1'b0; b8.dividend = '0; b8.divisor = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", b4.busy, 0);
        chk("rst_done", b4.done, 0);
        chk("rst_quotient", b4.quotient, 0);
        chk("rst_remainder", b4.remainder, 0);
        chk("rst_dbz", b4.div_by_zero, 0);
        n_rst = 1'b1;

        // 13/3: latency, busy duration and post-done stability.
        issue4(13, 3, 1'b1);
        measure4(lat, bc);
        chk("lat_13_3", lat, 5);
        chk("busy_13_3", bc, 5);
        chk("q_at_done_13_3", b4.quotient, 4);
        chk("r_at_done_13_3", b4.remainder, 1);
        @(negedge clk);
        chk("busy_after_done", b4.busy, 0);
        repeat (3) @(negedge clk);
        chk("q_stable_idle", b4.quotient, 4);
        chk("r_stable_idle", b4.remainder, 1);

        run4(15, 1);
        run4(2, 9);

        // Divide by zero short path, then a normal divide clears the flag.
        issue4(11, 0, 1'b1);
        measure4(lat, bc);
        chk("lat_div0", lat, 1);
        chk("dbz_flag", b4.div_by_zero, 1);
        wait_idle4();
        run4(7, 2);
        chk("dbz_cleared", b4.div_by_zero, 0);

        // Start pulse mid-CALC with other operands must be ignored.
        issue4(13, 3, 1'b1);
        @(negedge clk);
        @(negedge clk);
        b4.dividend = 4'd7;
        b4.divisor  = 4'd2;
        b4.start    = 1'b1;
        @(posedge clk);
        #1 b4.start = 1'b0;
        wait_idle4();
        chk("q_after_ignored_start", b4.quotient, 4);

        // Start held high: back-to-back operations every WIDTH+2 cycles.
        wait_idle4();
        for (int i = 0; i < 3; i++) begin
            q4.push_back(model(9, 2, 4));
            pushed4++;
        end
        b4.dividend = 4'd9;
        b4.divisor  = 4'd2;
        b4.start    = 1'b1;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (b4.done) begin
                t[n] = cyc;
                n++;
                if (n == 3) begin
                    b4.start = 1'b0;
                    break;
                end
            end
        end
        b4.start = 1'b0;
        chk("held_start_dones", n, 3);
        if (n == 3) begin
            chk("period_1", t[1] - t[0], 6);
            chk("period_2", t[2] - t[1], 6);
        end
        wait_idle4();

        // Asynchronous reset during the third CALC cycle: outputs clear, no done.
        issue4(13, 3, 1'b0);
        repeat (3) @(negedge clk);
        n_rst = 1'b0;
        #1;
        chk("arst_busy", b4.busy, 0);
        chk("arst_done", b4.done, 0);
        chk("arst_quotient", b4.quotient, 0);
        chk("arst_remainder", b4.remainder, 0);
        chk("arst_dbz", b4.div_by_zero, 0);
        @(negedge clk);
        n_rst = 1'b1;
        repeat (8) @(negedge clk);
        run4(14, 4);

        // Exhaustive 4-bit sweep.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                run4(a, b);
            end
        end

        // 8-bit instance: boundaries then random pairs.
        run8(200, 7);
        run8(255, 0);
        run8(255, 255);
        run8(3, 200);
        run8(255, 1);
        for (int i = 0; i < 30; i++) begin
            run8($urandom_range(0, 255), $urandom_range(1, 255));
        end

        repeat (3) @(negedge clk);
        chk("pending4", q4.size(), 0);
        chk("pending8", q8.size(), 0);
        chk("done_count4", dones4, pushed4);
        chk("done_count8", dones8, pushed8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_sub_div.md
Name: shift_sub_div

Overview:
- Sequential restoring (shift-subtract) unsigned divider. It is the inverse of the team's shift-add multiplier.
- Produces one quotient bit per clock, MSB first, from a dividend and divisor latched on start.
- Sits beside the multiplier in the arithmetic datapath and uses the same start-driven style, plus an explicit busy/done handshake.

Parameters:
- WIDTH, 4, operand width in bits for dividend, divisor, quotient and remainder (WIDTH >= 2).

Ports:
- clk  input  1  rising-edge clock
- n_rst  input  1  asynchronous active-low reset
- start  input  1  request pulse; sampled only in IDLE
- dividend  input  WIDTH  unsigned numerator; latched when start is accepted
- divisor  input  WIDTH  unsigned denominator; latched when start is accepted
- busy  output  1  high in CALC and DONE
- done  output  1  one-cycle pulse; results valid
- quotient  output  WIDTH  floor(dividend/divisor); held until the next accepted start
- remainder  output  WIDTH  dividend mod divisor; held until the next accepted start
- div_by_zero  output  1  set with done when divisor was 0; held with results

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - state=IDLE, step counter=0.
  - busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
  - The operation in progress is discarded. No done is produced for it.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - start=1 at edge k: latch the divisor; load the quotient/shift register with the dividend; clear the partial remainder (WIDTH+1 bits); clear div_by_zero; counter=WIDTH.
  - If the latched divisor==0: go directly to DONE at edge k with quotient=all ones, remainder=dividend, div_by_zero=1.
  - Otherwise go to CALC.
- CALC, on each edge:
  - Shift {rem, q} left by 1.
  - trial = shifted rem - {1'b0, divisor}, computed in WIDTH+1 bits.
  - If trial is non-negative (MSB=0): rem=trial and q[0]=1. Otherwise rem keeps its shifted value and q[0]=0.
  - Decrement counter. On the edge where counter goes 1->0, go to DONE.
- DONE:
  - done=1 for exactly one cycle. quotient/remainder outputs reflect the final registers.
  - Next edge: go to IDLE unconditionally.
- Latency:
  - Normal divide: start accepted at edge k, done high in the cycle following edge k+WIDTH, so total WIDTH+1 edges from acceptance to done.
  - Divide by zero: done high in the cycle following edge k.
- busy is high throughout CALC and DONE. start is ignored while busy=1, including a start coincident with done. Operand changes while busy have no effect.
- start held high continuously: a new operation is accepted on the first IDLE cycle after each DONE. This gives back-to-back operations every WIDTH+2 cycles.
- Results (quotient, remainder, div_by_zero) are stable from done until the edge that accepts the next start. They change only in CALC/DONE, never in IDLE.
- Arithmetic is unsigned only. The partial remainder is kept at WIDTH+1 bits so the trial subtraction never overflows. The final remainder is always < divisor, truncated to WIDTH bits without loss.
- dividend < divisor: quotient=0, remainder=dividend, normal latency.

Decomposition:
- Shared package (arith_pkg):
  - FSM state enum {IDLE, CALC, DONE}.
  - Default WIDTH constant, also shared with the multiplier.
  - Localparam for counter width = $clog2(WIDTH+1).
- One natural sub-module: div_step, a combinational single restoring step.
  - Inputs: rem, next dividend bit, divisor.
  - Outputs: new rem, quotient bit.
  - Instantiated once and reused across cycles.
- FSM, counter and registers stay in the top module.

Test Plan:
- WIDTH=4: reset, then start with dividend=13, divisor=3 -> done pulses exactly 5 edges after acceptance; quotient=4, remainder=1, div_by_zero=0; busy high for 5 cycles.
- dividend=15, divisor=1 -> quotient=15, remainder=0. Then dividend=2, divisor=9 -> quotient=0, remainder=2.
- divisor=0, dividend=11 -> done one edge after acceptance; quotient=4'hF, remainder=11, div_by_zero=1. Next normal divide clears div_by_zero.
- Pulse start again mid-CALC with different operands -> ignored; the original result is unchanged. Hold start high -> operations repeat every 6 cycles. Results are stable between done pulses.
- Assert n_rst low during the 3rd CALC cycle -> all outputs 0 immediately (asynchronous), no done. A new start after release gives a correct result.
- Exhaustive sweep of all 256 operand pairs at WIDTH=4, plus random pairs at WIDTH=8:
  - divisor != 0: quotient*divisor + remainder == dividend and remainder < divisor.
  - Every operation produces exactly one done pulse.
